// File: rtl/shim_pkg.sv
// Types and constants shared by the align and split shims.
package shim_pkg;

  typedef enum logic [0:0] {
    SHIM_IDLE     = 1'b0,
    SHIM_DISPATCH = 1'b1
  } shim_state_t;

  // Value registers come out of reset cleared; wide enough for any lane width up to 64.
  localparam logic [63:0] SHIM_VALUE_RST = '0;

endpackage

// File: rtl/shim_split_lane.sv
// One fork lane: holds a value and its pending flag until the consumer takes it.
module shim_split_lane
  import shim_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] value,
  output logic             done_next
);

  logic             pending_reg;
  logic             pending_next;
  logic [WIDTH-1:0] value_reg;

  always_comb begin
    pending_next = pending_reg;
    if (load)
      pending_next = 1'b1;
    else if (clear)
      pending_next = 1'b0;
    else if (pending_reg && ready)
      pending_next = 1'b0;
  end

  // Natural completion only; the watchdog clear is kept out to avoid a loop through the FSM.
  assign done_next = ~pending_reg | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      value_reg   <= SHIM_VALUE_RST[WIDTH-1:0];
    end else begin
      pending_reg <= pending_next;
      if (load)
        value_reg <= load_value;
    end
  end

  assign valid = pending_reg;
  assign value = value_reg;

endmodule

// File: rtl/shim_split.sv
// Broadcast/fork shim: one vector in, one independent valid/ready per lane out.
// Optional watchdog enabled by defining SHIM_SPLIT_TIMEOUT_EN.
module shim_split
  import shim_pkg::*;
#(
  parameter int NUM_OUTPUTS    = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic [NUM_OUTPUTS*WIDTH-1:0] VALUES_IN,
  input  logic                         VALID_IN,
  output logic                         READY_OUT,
  output logic [NUM_OUTPUTS*WIDTH-1:0] VALUES_OUT,
  output logic [NUM_OUTPUTS-1:0]       VALIDS_OUT,
  input  logic [NUM_OUTPUTS-1:0]       READYS_IN,
  output logic                         BUSY_OUT,
  output logic                         TIMEOUT_OUT
);

  shim_state_t            state_reg;
  logic                   accept;
  logic                   all_done;
  logic                   expire;
  logic [NUM_OUTPUTS-1:0] pending;
  logic [NUM_OUTPUTS-1:0] done_next;

  assign accept   = VALID_IN && (state_reg == SHIM_IDLE);
  assign all_done = &done_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_lane
      shim_split_lane #(.WIDTH(WIDTH)) u_lane (
        .clk        (CLK),
        .rst_n      (RSTN),
        .load       (accept),
        .clear      (expire),
        .load_value (VALUES_IN[gi*WIDTH +: WIDTH]),
        .ready      (READYS_IN[gi]),
        .valid      (pending[gi]),
        .value      (VALUES_OUT[gi*WIDTH +: WIDTH]),
        .done_next  (done_next[gi])
      );
    end
  endgenerate

`ifdef SHIM_SPLIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;
  logic          timeout_reg;

  // Normal completion on the limit edge wins over the watchdog.
  assign expire = (state_reg == SHIM_DISPATCH) && (count_reg == CW'(TIMEOUT_CYCLES)) && !all_done;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= expire;
      if (accept)
        count_reg <= '0;
      else if (state_reg == SHIM_DISPATCH)
        count_reg <= count_reg + CW'(1);
    end
  end

  assign TIMEOUT_OUT = timeout_reg;
`else
  assign expire      = 1'b0;
  assign TIMEOUT_OUT = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= SHIM_IDLE;
    end else begin
      case (state_reg)
        SHIM_IDLE:     if (accept) state_reg <= SHIM_DISPATCH;
        SHIM_DISPATCH: if (all_done || expire) state_reg <= SHIM_IDLE;
        default:       state_reg <= SHIM_IDLE;
      endcase
    end
  end

  assign READY_OUT  = (state_reg == SHIM_IDLE);
  assign VALIDS_OUT = pending;
  assign BUSY_OUT   = |pending;

endmodule

// File: tb/tb_shim_split.sv
// Scoreboard bench for shim_split: per-lane expected-value queues filled on accept, drained on handshake.
module tb_shim_split;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic [N*W-1:0] VALUES_IN = '0;
  logic         VALID_IN = 1'b0;
  logic         READY_OUT;
  logic [N*W-1:0] VALUES_OUT;
  logic [N-1:0] VALIDS_OUT;
  logic [N-1:0] READYS_IN = '0;
  logic         BUSY_OUT;
  logic         TIMEOUT_OUT;

  shim_split #(.NUM_OUTPUTS(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .VALID_IN(VALID_IN),
    .READY_OUT(READY_OUT), .VALUES_OUT(VALUES_OUT), .VALIDS_OUT(VALIDS_OUT),
    .READYS_IN(READYS_IN), .BUSY_OUT(BUSY_OUT), .TIMEOUT_OUT(TIMEOUT_OUT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int delivered = 0;
  int timeouts = 0;
  int age = 0;
  logic exp_to = 1'b0;
  logic [W-1:0] lane_q [N][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  // Reference: a vector is outstanding while any lane queue holds a value.
  always @(posedge CLK or negedge RSTN) begin
    bit idle_before;
    bit any_left;
    bit to_now;
    if (!RSTN) begin
      for (int i = 0; i < N; i++) lane_q[i].delete();
      exp_to = 1'b0;
      #1;
      check("rst_valids", 64'(VALIDS_OUT), 64'd0);
      check("rst_ready", 64'(READY_OUT), 64'd1);
      check("rst_busy", 64'(BUSY_OUT), 64'd0);
    end else begin
      idle_before = 1'b1;
      for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) idle_before = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (lane_q[i].size() != 0 && READYS_IN[i]) begin
          void'(lane_q[i].pop_front());
          delivered++;
        end
      end
      to_now = 1'b0;
`ifdef SHIM_SPLIT_TIMEOUT_EN
      if (!idle_before) begin
        any_left = 1'b0;
        for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) any_left = 1'b1;
        if (age == TO && any_left) begin
          for (int i = 0; i < N; i++) lane_q[i].delete();
          to_now = 1'b1;
          timeouts++;
          $display("timeout after %0d dispatch cycles", TO);
        end
        age++;
      end
`endif
      if (VALID_IN && idle_before) begin
        for (int i = 0; i < N; i++) lane_q[i].push_back(VALUES_IN[i*W +: W]);
        age = 0;
        accepts++;
        $display("accept #%0d values=%h", accepts, VALUES_IN);
      end
      exp_to = to_now;
      #1;
      any_left = 1'b0;
      for (int i = 0; i < N; i++) begin
        check($sformatf("valid[%0d]", i), 64'(VALIDS_OUT[i]), 64'(lane_q[i].size() != 0));
        if (lane_q[i].size() != 0) begin
          any_left = 1'b1;
          check($sformatf("value[%0d]", i), 64'(VALUES_OUT[i*W +: W]), 64'(lane_q[i][0]));
        end
      end
      check("ready_out", 64'(READY_OUT), 64'(!any_left));
      check("busy_out", 64'(BUSY_OUT), 64'(any_left));
      check("timeout_out", 64'(TIMEOUT_OUT), 64'(exp_to));
    end
  end

  task automatic drive(input logic v, input logic [N*W-1:0] d, input logic [N-1:0] r);
    @(negedge CLK);
    VALID_IN  = v;
    VALUES_IN = d;
    READYS_IN = r;
  endtask

  initial begin
    int base_acc;
    int base_del;
    #2;
    check("rst_values", 64'(VALUES_OUT), 64'd0);
    check("rst_to", 64'(TIMEOUT_OUT), 64'd0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;

    // Back-to-back at full rate: two vectors in four cycles.
    base_acc = accepts;
    repeat (4) drive(1'b1, pack4(5, -3, 127, -128), 4'hF);
    drive(1'b0, '0, 4'hF);
    check("full_rate_accepts", 64'(accepts - base_acc), 64'd2);

    // Staggered per-lane readiness.
    drive(1'b0, '0, 4'h0);
    base_del = delivered;
    drive(1'b1, pack4(11, -22, 33, -44), 4'h0);
    for (int k = 1; k <= 6; k++)
      drive(1'b0, '0, {k >= 6, k >= 2, k >= 3, k >= 1});
    drive(1'b0, '0, 4'h0);
    check("stagger_delivered", 64'(delivered - base_del), 64'd4);

    // New data offered during dispatch must wait.
    drive(1'b1, pack4(7, 8, 9, 10), 4'h0);
    repeat (3) drive(1'b1, pack4(1, 1, 1, 1), 4'h0);
    repeat (3) drive(1'b1, pack4(1, 1, 1, 1), 4'hF);
    drive(1'b0, '0, 4'h0);

    // Asynchronous reset with two lanes still pending.
    drive(1'b1, pack4(21, 22, 23, 24), 4'h0);
    drive(1'b0, '0, 4'b0011);
    drive(1'b0, '0, 4'h0);
    #2 RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    base_del = delivered;
    drive(1'b1, pack4(9, 9, 9, 9), 4'h0);
    drive(1'b0, '0, 4'hF);
    drive(1'b0, '0, 4'h0);
    check("post_reset_delivered", 64'(delivered - base_del), 64'd4);

    // Consumer ready while idle has no effect.
    repeat (3) drive(1'b0, pack4(3, 3, 3, 3), 4'b0100);

`ifdef SHIM_SPLIT_TIMEOUT_EN
    drive(1'b1, pack4(4, 5, 6, 7), 4'h0);
    repeat (12) drive(1'b0, '0, 4'b0111);
    check("timeout_count", 64'(timeouts), 64'd1);
    drive(1'b1, pack4(4, 5, 6, 7), 4'h0);
    for (int k = 1; k <= 9; k++) drive(1'b0, '0, {k == 9, 3'b111});
    drive(1'b0, '0, 4'h0);
    check("no_timeout_at_limit", 64'(timeouts), 64'd1);
`endif

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 9) < 6);
      drive(($urandom_range(0, 3) != 0), N*W'($urandom()), r);
    end
    repeat (20) drive(1'b0, '0, 4'hF);
    check("random_progress", 64'(delivered > 400), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
